upstream_processor: RTL and testbench

//  Control FSM on the order-entry upstream path, between the order generator and the

---
 rtl/upstream_pkg.sv | 37 +++
 rtl/upstream_processor.sv | 86 ++++++++
 tb/tb_upstream_processor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/upstream_pkg.sv
// Shared types and output-decode constants for the upstream order-entry controller.
package upstream_pkg;

  typedef enum logic [2:0] {
    IDLE              = 3'd0,
    NEWMAX            = 3'd1,
    RISKCHECK         = 3'd2,
    SENDORDER         = 3'd3,
    RISKCHK_SENDORDER = 3'd4
  } up_state_t;

  // Strobe bundle in {check_risk, send_order, update_max} order.
  typedef struct packed {
    logic check_risk;
    logic send_order;
    logic update_max;
  } up_out_t;

  localparam up_out_t OUT_IDLE              = 3'b000;
  localparam up_out_t OUT_NEWMAX            = 3'b001;
  localparam up_out_t OUT_RISKCHECK         = 3'b100;
  localparam up_out_t OUT_SENDORDER         = 3'b010;
  localparam up_out_t OUT_RISKCHK_SENDORDER = 3'b110;

  // Moore output decode; unencoded states give no strobes.
  function automatic up_out_t decode_outputs(input up_state_t st);
    case (st)
      IDLE:              decode_outputs = OUT_IDLE;
      NEWMAX:            decode_outputs = OUT_NEWMAX;
      RISKCHECK:         decode_outputs = OUT_RISKCHECK;
      SENDORDER:         decode_outputs = OUT_SENDORDER;
      RISKCHK_SENDORDER: decode_outputs = OUT_RISKCHK_SENDORDER;
      default:           decode_outputs = OUT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/upstream_processor.sv
// Upstream control FSM: sequences max-limit updates, pre-trade risk checks and
// order sends, overlapping the send of one order with the check of the next.
module upstream_processor
  import upstream_pkg::*;
#(
  parameter int unsigned RISK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic risk_ok,
  input  logic new_order,
  input  logic new_max,
  input  logic memwr,
  output logic check_risk,
  output logic send_order,
  output logic update_max
);

  // At least one bit so a disabled timeout still elaborates cleanly.
  localparam int unsigned CW = (RISK_TIMEOUT > 0) ? $clog2(RISK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (RISK_TIMEOUT > 0) ? CW'(RISK_TIMEOUT - 1) : '0;

  up_state_t     state_q;
  up_state_t     state_d;
  logic [CW-1:0] cnt_q;
  logic          timeout;
  up_out_t       outs;

  assign timeout = (RISK_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; first matching condition wins in each state.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (new_max)        state_d = NEWMAX;
        else if (new_order) state_d = RISKCHECK;
        else                state_d = IDLE;
      end
      NEWMAX: begin
        state_d = memwr ? IDLE : NEWMAX;
      end
      RISKCHECK: begin
        if (risk_ok && new_order) state_d = RISKCHK_SENDORDER;
        else if (risk_ok)         state_d = SENDORDER;
        else if (timeout)         state_d = IDLE;
        else                      state_d = RISKCHECK;
      end
      SENDORDER: begin
        if (memwr && new_order) state_d = RISKCHECK;
        else if (memwr)         state_d = IDLE;
        else                    state_d = SENDORDER;
      end
      RISKCHK_SENDORDER: begin
        if (risk_ok && new_order) state_d = RISKCHK_SENDORDER;
        else if (risk_ok)         state_d = SENDORDER;
        else                      state_d = RISKCHECK;
      end
      default: state_d = IDLE;
    endcase
  end

  // Risk-check timeout counter; being outside RISKCHECK clears it, which also
  // covers the clear-on-entry case. Saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n)                                  cnt_q <= '0;
    else if (state_q != RISKCHECK || risk_ok)    cnt_q <= '0;
    else if (cnt_q != '1)                        cnt_q <= cnt_q + CW'(1);
  end

  // Moore output decode from the state register only.
  always_comb begin
    outs = decode_outputs(state_q);
  end

  assign check_risk = outs.check_risk;
  assign send_order = outs.send_order;
  assign update_max = outs.update_max;

endmodule

// File: tb/tb_upstream_processor.sv
// Scoreboard bench for upstream_processor: expected strobes are queued as each
// stimulus cycle is driven and compared one clock edge later. A second instance
// with the timeout disabled shares the stimulus.
module tb_upstream_processor;

  logic clk = 1'b0;
  logic rst_n, risk_ok, new_order, new_max, memwr;
  logic check_risk, send_order, update_max;
  logic check_risk0, send_order0, update_max0;

  int checks = 0;
  int errors = 0;

  logic [2:0] q_exp[$];
  logic [2:0] q_exp0[$];
  string      q_tag[$];

  always #5 clk = ~clk;

  upstream_processor #(.RISK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .risk_ok(risk_ok), .new_order(new_order),
    .new_max(new_max), .memwr(memwr),
    .check_risk(check_risk), .send_order(send_order), .update_max(update_max)
  );

  upstream_processor #(.RISK_TIMEOUT(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .risk_ok(risk_ok), .new_order(new_order),
    .new_max(new_max), .memwr(memwr),
    .check_risk(check_risk0), .send_order(send_order0), .update_max(update_max0)
  );

  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs (just after a negedge) and queue the strobes
  // expected after the following posedge for both instances.
  task automatic step(input logic rn, input logic nm, input logic no,
                      input logic ro, input logic mw,
                      input logic [2:0] exp, input logic [2:0] exp0, input string tag);
    rst_n = rn; new_max = nm; new_order = no; risk_ok = ro; memwr = mw;
    q_exp.push_back(exp);
    q_exp0.push_back(exp0);
    q_tag.push_back(tag);
    @(negedge clk);
  endtask

  // Monitor: sample shortly after each active edge and retire one entry.
  always @(posedge clk) begin
    #1;
    if (q_exp.size() > 0) begin
      string      t;
      logic [2:0] e;
      logic [2:0] e0;
      t  = q_tag.pop_front();
      e  = q_exp.pop_front();
      e0 = q_exp0.pop_front();
      check_eq(t, {check_risk, send_order, update_max}, e);
      check_eq({t, "_nt"}, {check_risk0, send_order0, update_max0}, e0);
    end
  end

  initial begin
    rst_n = 1'b0; risk_ok = 1'b0; new_order = 1'b0; new_max = 1'b0; memwr = 1'b0;
    @(negedge clk);

    //     rn  nm  no  ro  mw   exp     exp0
    step(0, 0, 0, 0, 0, 3'b000, 3'b000, "reset");
    step(1, 0, 0, 0, 0, 3'b000, 3'b000, "idle");
    step(1, 0, 0, 0, 1, 3'b000, 3'b000, "memwr_ign_idle");

    // Max-limit update and priority over new_order
    step(1, 1, 0, 0, 0, 3'b001, 3'b001, "newmax");
    step(1, 0, 0, 0, 1, 3'b000, 3'b000, "newmax_done");
    step(1, 1, 1, 0, 0, 3'b001, 3'b001, "newmax_prio");
    step(1, 1, 1, 1, 0, 3'b001, 3'b001, "newmax_hold");
    step(1, 0, 0, 0, 1, 3'b000, 3'b000, "newmax_done2");

    // Single order: check, send, complete
    step(1, 0, 1, 0, 0, 3'b100, 3'b100, "rc_enter");
    step(1, 0, 0, 1, 0, 3'b010, 3'b010, "send");
    step(1, 0, 0, 0, 0, 3'b010, 3'b010, "send_hold");
    step(1, 0, 0, 0, 1, 3'b000, 3'b000, "send_done");

    // Overlapped check/send
    step(1, 0, 1, 0, 0, 3'b100, 3'b100, "rc_enter2");
    step(1, 0, 1, 1, 0, 3'b110, 3'b110, "overlap");
    step(1, 0, 1, 1, 1, 3'b110, 3'b110, "overlap_hold");
    step(1, 0, 0, 1, 1, 3'b010, 3'b010, "overlap_to_send");
    step(1, 0, 0, 0, 1, 3'b000, 3'b000, "send_done2");

    // Send completing with another order pending, overlap falling back to check
    step(1, 0, 1, 0, 0, 3'b100, 3'b100, "rc_enter3");
    step(1, 0, 0, 1, 0, 3'b010, 3'b010, "send3");
    step(1, 0, 1, 0, 1, 3'b100, 3'b100, "send_to_rc");
    step(1, 0, 1, 1, 0, 3'b110, 3'b110, "overlap3");
    step(1, 0, 1, 0, 0, 3'b100, 3'b100, "overlap_to_rc");
    step(1, 0, 0, 1, 0, 3'b010, 3'b010, "send4");
    step(1, 0, 0, 0, 1, 3'b000, 3'b000, "send_done4");

    // Timeout: 16 edges in RISKCHECK with risk_ok=0 return to IDLE;
    // the disabled-timeout instance stays in RISKCHECK.
    step(1, 0, 1, 0, 0, 3'b100, 3'b100, "to_enter");
    for (int unsigned i = 1; i <= 15; i++)
      step(1, 0, 0, 0, 0, 3'b100, 3'b100, $sformatf("to_wait%0d", i));
    step(1, 0, 0, 0, 0, 3'b000, 3'b100, "to_expire");
    for (int unsigned i = 0; i < 8; i++)
      step(1, 0, 0, 0, 0, 3'b000, 3'b100, $sformatf("to_after%0d", i));
    step(0, 0, 0, 0, 0, 3'b000, 3'b000, "to_reset");

    // Timeout restarts from zero on each new entry to RISKCHECK
    step(1, 0, 1, 0, 0, 3'b100, 3'b100, "to2_enter");
    for (int unsigned i = 1; i <= 15; i++)
      step(1, 0, 0, 0, 0, 3'b100, 3'b100, $sformatf("to2_wait%0d", i));
    step(1, 0, 0, 0, 0, 3'b000, 3'b100, "to2_expire");
    step(0, 0, 0, 0, 0, 3'b000, 3'b000, "to2_reset");

    // Reset while overlapped, held low, then released
    step(1, 0, 1, 0, 0, 3'b100, 3'b100, "rst_rc");
    step(1, 0, 1, 1, 0, 3'b110, 3'b110, "rst_overlap");
    step(0, 0, 1, 1, 0, 3'b000, 3'b000, "rst_mid");
    step(0, 1, 1, 1, 1, 3'b000, 3'b000, "rst_hold");
    step(1, 0, 1, 0, 0, 3'b100, 3'b100, "rst_release");

    step(1, 0, 0, 0, 0, 3'b100, 3'b100, "final");
    @(posedge clk);
    #2;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog time=%0t limit=100000", $time);
    $fatal(1, "watchdog");
  end

endmodule
